mod_n_counter: RTL and testbench

//  Parametrised synchronous modulo-N counter; successor to the fixed mod-5 ripple counter.

---
 rtl/mod_n_counter.sv | 86 ++++++++
 tb/tb_mod_n_counter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mod_n_counter.sv
// Modulo-N counter. It counts up or down, and it can do a parallel load.
// At the bounds it either wraps or saturates.
// tc_o is combinational so that it can drive the enable of the next stage in a cascade.
module mod_n_counter #(
  parameter int N        = 5,
  parameter bit SATURATE = 1'b0,
  parameter int INIT     = 0,
  localparam int W       = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic         up_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] count_o,
  output logic         tc_o,
  output logic         wrap_o,
  output logic         err_o
);

  localparam logic [W-1:0] MAX_V  = W'(N - 1);
  localparam logic [W-1:0] INIT_V = W'(INIT);
  // The range check is one bit wider, so it is exact when N is a power of two.
  localparam logic [W:0]   N_EXT  = (W + 1)'(N);

  logic         at_max, at_min, at_bound, load_ok;
  logic [W-1:0] count_nxt;
  logic         wrap_nxt, err_nxt;

  assign at_max   = (count_o == MAX_V);
  assign at_min   = (count_o == '0);
  assign at_bound = up_i ? at_max : at_min;
  assign load_ok  = ({1'b0, load_val_i} < N_EXT);
  assign tc_o     = en_i & at_bound;

  // Next-state selection. Priority order is clear, then load, then enable, then hold.
  // The bounds are compared explicitly, so the counter never depends on W-bit overflow.
  always_comb begin
    count_nxt = count_o;
    wrap_nxt  = 1'b0;
    err_nxt   = err_o;
    if (clear_i) begin
      count_nxt = INIT_V;
      err_nxt   = 1'b0;
    end else if (load_i) begin
      if (load_ok) begin
        count_nxt = load_val_i;
      end else begin
        count_nxt = MAX_V;
        err_nxt   = 1'b1;
      end
    end else if (en_i) begin
      if (up_i) begin
        if (at_max) begin
          count_nxt = SATURATE ? MAX_V : '0;
          wrap_nxt  = !SATURATE;
        end else begin
          count_nxt = count_o + 1'b1;
        end
      end else begin
        if (at_min) begin
          count_nxt = SATURATE ? '0 : MAX_V;
          wrap_nxt  = !SATURATE;
        end else begin
          count_nxt = count_o - 1'b1;
        end
      end
    end
  end

  // State registers. Reset is asynchronous and returns the counter to INIT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_o <= INIT_V;
      wrap_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      count_o <= count_nxt;
      wrap_o  <= wrap_nxt;
      err_o   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mod_n_counter.sv
// Bench for mod_n_counter. Four counters with different parameters share one stimulus:
// N=5 wrap, N=6 saturate, N=1 wrap and N=8 wrap.
// Two cascaded N=3 stages also run alongside and must form a mod-9 counter.
// Expected values come from an integer reference model and are queued as a scoreboard.
module tb_mod_n_counter;

  logic clk = 1'b0;
  logic rst_n;
  logic clear, en, up, load;
  logic [2:0] lv;

  logic [2:0] c5, c6, c8;
  logic [0:0] c1;
  logic [3:0] tc, wr, er;

  logic [1:0] lo_cnt, hi_cnt;
  logic       lo_tc, hi_tc, lo_wr, hi_wr, lo_er, hi_er;
  logic [1:0] zero2;
  assign zero2 = 2'd0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mod_n_counter #(.N(5), .SATURATE(1'b0), .INIT(0)) u5 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .en_i(en), .up_i(up), .load_i(load),
    .load_val_i(lv), .count_o(c5), .tc_o(tc[0]), .wrap_o(wr[0]), .err_o(er[0]));
  mod_n_counter #(.N(6), .SATURATE(1'b1), .INIT(0)) u6 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .en_i(en), .up_i(up), .load_i(load),
    .load_val_i(lv), .count_o(c6), .tc_o(tc[1]), .wrap_o(wr[1]), .err_o(er[1]));
  mod_n_counter #(.N(1), .SATURATE(1'b0), .INIT(0)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .en_i(en), .up_i(up), .load_i(load),
    .load_val_i(lv[0:0]), .count_o(c1), .tc_o(tc[2]), .wrap_o(wr[2]), .err_o(er[2]));
  mod_n_counter #(.N(8), .SATURATE(1'b0), .INIT(0)) u8 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .en_i(en), .up_i(up), .load_i(load),
    .load_val_i(lv), .count_o(c8), .tc_o(tc[3]), .wrap_o(wr[3]), .err_o(er[3]));

  // Cascade: the low stage always counts up when en is high.
  // The high stage is enabled by the terminal count of the low stage.
  mod_n_counter #(.N(3), .SATURATE(1'b0), .INIT(0)) u_lo (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .en_i(en), .up_i(1'b1), .load_i(1'b0),
    .load_val_i(zero2), .count_o(lo_cnt), .tc_o(lo_tc), .wrap_o(lo_wr), .err_o(lo_er));
  mod_n_counter #(.N(3), .SATURATE(1'b0), .INIT(0)) u_hi (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .en_i(lo_tc), .up_i(1'b1), .load_i(1'b0),
    .load_val_i(zero2), .count_o(hi_cnt), .tc_o(hi_tc), .wrap_o(hi_wr), .err_o(hi_er));

  typedef struct {
    int cnt [4];
    int wrp [4];
    int err [4];
    int casc;
  } exp_t;

  exp_t sb [$];

  int mn  [4] = '{5, 6, 1, 8};
  int msat[4] = '{0, 1, 0, 0};
  int mc  [4];
  int mw  [4];
  int me  [4];
  int mcasc;

  function automatic int dut_cnt(int i);
    case (i)
      0: return int'(c5);
      1: return int'(c6);
      2: return int'(c1);
      default: return int'(c8);
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mc[i] = 0; mw[i] = 0; me[i] = 0;
    end
    mcasc = 0;
  endtask

  task automatic check_all(input string tag, input exp_t e);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_cnt%0d", tag, mn[i]), dut_cnt(i), e.cnt[i]);
      chk($sformatf("%s_wrap%0d", tag, mn[i]), int'(wr[i]), e.wrp[i]);
      chk($sformatf("%s_err%0d", tag, mn[i]), int'(er[i]), e.err[i]);
    end
    chk({tag, "_casc"}, int'(hi_cnt) * 3 + int'(lo_cnt), e.casc);
  endtask

  // One clock step. Drive the inputs, check tc_o combinationally, and push the model's
  // next state to the scoreboard. Then clock, pop the entry and compare it.
  task automatic step(input string tag, input bit c, input bit l, input bit e, input bit u,
                      input logic [2:0] v);
    exp_t x;
    int lvi, bound;
    clear = c; load = l; en = e; up = u; lv = v;
    #1;
    for (int i = 0; i < 4; i++) begin
      bound = u ? mn[i] - 1 : 0;
      chk($sformatf("%s_tc%0d", tag, mn[i]), int'(tc[i]), (e && mc[i] == bound) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) begin
      lvi = (mn[i] == 1) ? int'(v[0]) : int'(v);
      mw[i] = 0;
      if (c) begin
        mc[i] = 0; me[i] = 0;
      end else if (l) begin
        if (lvi < mn[i]) mc[i] = lvi;
        else begin
          mc[i] = mn[i] - 1; me[i] = 1;
        end
      end else if (e) begin
        if (u) begin
          if (mc[i] == mn[i] - 1) begin
            mc[i] = msat[i] ? mn[i] - 1 : 0; mw[i] = msat[i] ? 0 : 1;
          end else mc[i] = mc[i] + 1;
        end else begin
          if (mc[i] == 0) begin
            mc[i] = msat[i] ? 0 : mn[i] - 1; mw[i] = msat[i] ? 0 : 1;
          end else mc[i] = mc[i] - 1;
        end
      end
    end
    if (c) mcasc = 0;
    else if (e) mcasc = (mcasc + 1) % 9;
    x.cnt = mc; x.wrp = mw; x.err = me; x.casc = mcasc;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      x = sb.pop_front();
      check_all(tag, x);
    end
  endtask

  initial begin
    exp_t z;
    rst_n = 1'b0; clear = 0; load = 0; en = 0; up = 1; lv = '0;
    model_reset();
    #3;
    z.cnt = mc; z.wrp = mw; z.err = me; z.casc = mcasc;
    check_all("reset", z);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Count up 12 times: 0..4 wrap on N=5, saturate on N=6, and wrap continuously on N=1.
    for (int k = 0; k < 12; k++) step("up", 0, 0, 1, 1, 3'd0);
    // Count down from 0, which wraps to N-1 at once.
    step("clr", 1, 0, 0, 1, 3'd0);
    for (int k = 0; k < 6; k++) step("down", 0, 0, 1, 0, 3'd0);
    // Saturation run: 8 steps up, then 8 steps down.
    step("clr", 1, 0, 0, 1, 3'd0);
    for (int k = 0; k < 8; k++) step("sat_up", 0, 0, 1, 1, 3'd0);
    for (int k = 0; k < 8; k++) step("sat_dn", 0, 0, 1, 0, 3'd0);
    // Hold when en is low.
    step("hold", 0, 0, 0, 1, 3'd0);
    // Out-of-range load of 7: err_o stays set through enabled cycles until clear_i.
    step("ld7", 0, 1, 0, 1, 3'd7);
    for (int k = 0; k < 10; k++) step("sticky", 0, 0, 1, 1, 3'd0);
    step("clr", 1, 0, 0, 1, 3'd0);
    // Loading exactly N is out of range for N=5 but in range for N=6 and N=8.
    step("ld5", 0, 1, 0, 1, 3'd5);
    step("inload", 0, 1, 0, 1, 3'd1);
    // Priority: clear beats load and enable; load beats enable.
    step("prio_clr", 1, 1, 1, 1, 3'd3);
    step("prio_ld", 0, 1, 1, 1, 3'd2);
    for (int k = 0; k < 2; k++) step("mid", 0, 0, 1, 1, 3'd0);
    // Asynchronous reset between clock edges takes effect with no clock.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    z.cnt = mc; z.wrp = mw; z.err = me; z.casc = mcasc;
    check_all("async_rst", z);
    rst_n = 1'b1;
    // Long up run: N=8 wraps at 7, and the cascade walks through the mod-9 sequence.
    for (int k = 0; k < 20; k++) step("long", 0, 0, 1, 1, 3'd0);
    for (int k = 0; k < 10; k++) step("rnd", 0, ($urandom_range(0, 5) == 0), 1,
                                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
